// File: rtl/collision_scanner.sv
// Bounding-box collision scanner: tests every object pair (i<j) once per scan,
// streams colliding pairs over valid/ready and accumulates a per-object hit mask.
module collision_scanner #(
    parameter int N_OBJ        = 8,
    parameter int COORD_W      = 8,
    parameter int IDX_W        = $clog2(N_OBJ),
    parameter int TOUCH_IS_HIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_active,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COORD_W-1:0] wr_w,
    input  logic [COORD_W-1:0] wr_h,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [N_OBJ-1:0]   hit_mask,
    output logic               pair_valid,
    input  logic               pair_ready,
    output logic [IDX_W-1:0]   pair_a,
    output logic [IDX_W-1:0]   pair_b
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Far corners are kept one bit wider so x+w / y+h never wrap.
    logic [COORD_W-1:0] r_x  [N_OBJ];
    logic [COORD_W-1:0] r_y  [N_OBJ];
    logic [COORD_W:0]   r_x2 [N_OBJ];
    logic [COORD_W:0]   r_y2 [N_OBJ];
    logic [N_OBJ-1:0]   r_act;

    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_j;
    logic [N_OBJ-1:0]   r_hit_mask;
    logic [IDX_W-1:0]   r_pair_a;
    logic [IDX_W-1:0]   r_pair_b;

    logic [COORD_W:0]   w_xi;
    logic [COORD_W:0]   w_xj;
    logic [COORD_W:0]   w_yi;
    logic [COORD_W:0]   w_yj;
    logic               w_x_ok;
    logic               w_y_ok;
    logic               w_hit;
    logic               w_last;
    logic               w_advance;
    logic [IDX_W-1:0]   w_i_nxt;
    logic [IDX_W-1:0]   w_j_nxt;

    always_comb begin
        w_xi = {1'b0, r_x[r_i]};
        w_xj = {1'b0, r_x[r_j]};
        w_yi = {1'b0, r_y[r_i]};
        w_yj = {1'b0, r_y[r_j]};
        if (TOUCH_IS_HIT != 0) begin
            w_x_ok = (w_xi <= r_x2[r_j]) && (w_xj <= r_x2[r_i]);
            w_y_ok = (w_yi <= r_y2[r_j]) && (w_yj <= r_y2[r_i]);
        end else begin
            w_x_ok = (w_xi < r_x2[r_j]) && (w_xj < r_x2[r_i]);
            w_y_ok = (w_yi < r_y2[r_j]) && (w_yj < r_y2[r_i]);
        end
        w_hit  = r_act[r_i] && r_act[r_j] && w_x_ok && w_y_ok;
        w_last = (r_i == IDX_W'(N_OBJ - 2)) && (r_j == IDX_W'(N_OBJ - 1));
    end

    always_comb begin
        if (r_j == IDX_W'(N_OBJ - 1)) begin
            w_i_nxt = r_i + IDX_W'(1);
            w_j_nxt = r_i + IDX_W'(2);
        end else begin
            w_i_nxt = r_i;
            w_j_nxt = r_j + IDX_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_hit) begin
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_advance = 1'b1;
                    if (w_last) w_state_nxt = ST_DONE;
                end
            end
            ST_EMIT: begin
                if (pair_ready) begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? ST_DONE : ST_SCAN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '{default: '0};
            r_y   <= '{default: '0};
            r_x2  <= '{default: '0};
            r_y2  <= '{default: '0};
            r_act <= '0;
        end else if (wr_en && (r_state == ST_IDLE)) begin
            r_x[wr_idx]   <= wr_x;
            r_y[wr_idx]   <= wr_y;
            r_x2[wr_idx]  <= {1'b0, wr_x} + {1'b0, wr_w};
            r_y2[wr_idx]  <= {1'b0, wr_y} + {1'b0, wr_h};
            r_act[wr_idx] <= wr_active;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i        <= '0;
            r_j        <= '0;
            r_hit_mask <= '0;
            r_pair_a   <= '0;
            r_pair_b   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_i        <= '0;
                r_j        <= IDX_W'(1);
                r_hit_mask <= '0;
            end else if (w_advance && !w_last) begin
                r_i <= w_i_nxt;
                r_j <= w_j_nxt;
            end
            if ((r_state == ST_SCAN) && w_hit) begin
                r_hit_mask[r_i] <= 1'b1;
                r_hit_mask[r_j] <= 1'b1;
                r_pair_a        <= r_i;
                r_pair_b        <= r_j;
            end
        end
    end

    assign busy       = (r_state == ST_SCAN) || (r_state == ST_EMIT);
    assign done       = (r_state == ST_DONE);
    assign pair_valid = (r_state == ST_EMIT);
    assign hit_mask   = r_hit_mask;
    assign pair_a     = r_pair_a;
    assign pair_b     = r_pair_b;

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner (N_OBJ=4): directed tables, expected
// pairs/masks queued by stimulus and consumed by an independent monitor.
module tb_collision_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_idx = '0;
    logic       wr_active = 1'b0;
    logic [7:0] wr_x = '0, wr_y = '0, wr_w = '0, wr_h = '0;
    logic       start = 1'b0;
    logic       pair_ready = 1'b0;

    logic       busy, done, pair_valid;
    logic [3:0] hit_mask;
    logic [1:0] pair_a, pair_b;
    logic       s_busy, s_done, s_pair_valid;
    logic [3:0] s_hit_mask;
    logic [1:0] s_pair_a, s_pair_b;

    collision_scanner #(.N_OBJ(4), .COORD_W(8), .TOUCH_IS_HIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_active(wr_active),
        .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h), .start(start),
        .busy(busy), .done(done), .hit_mask(hit_mask), .pair_valid(pair_valid),
        .pair_ready(pair_ready), .pair_a(pair_a), .pair_b(pair_b)
    );

    collision_scanner #(.N_OBJ(4), .COORD_W(8), .TOUCH_IS_HIT(0)) u_strict (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_active(wr_active),
        .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h), .start(start),
        .busy(s_busy), .done(s_done), .hit_mask(s_hit_mask), .pair_valid(s_pair_valid),
        .pair_ready(pair_ready), .pair_a(s_pair_a), .pair_b(s_pair_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int stall_n = 0;
    int rcnt = 0;

    logic [3:0] exp_pair_q[$];
    logic [3:0] exp_mask_q[$];
    int         exp_lat_q[$];

    logic       prev_stall = 1'b0;
    logic [1:0] prev_a = '0, prev_b = '0;
    logic       s_done_seen = 1'b0, s_pv_seen = 1'b0;
    logic [3:0] s_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer-side ready: either always ready, or stall stall_n cycles per pair.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_n == 0) begin
                pair_ready = 1'b1;
            end else if (!pair_valid) begin
                pair_ready = 1'b0;
                rcnt = 0;
            end else if (rcnt >= stall_n) begin
                pair_ready = 1'b1;
                rcnt = 0;
            end else begin
                pair_ready = 1'b0;
                rcnt++;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        int         l;
        if (rst_n) begin
            if (pair_valid && prev_stall) begin
                chk("stall_stable_a", pair_a, prev_a);
                chk("stall_stable_b", pair_b, prev_b);
            end
            if (pair_valid && pair_ready) begin
                if (exp_pair_q.size() == 0) begin
                    chk("unexpected_pair", 1, 0);
                end else begin
                    e = exp_pair_q.pop_front();
                    chk("pair_a", pair_a, e[3:2]);
                    chk("pair_b", pair_b, e[1:0]);
                end
            end
            prev_stall = pair_valid && !pair_ready;
            prev_a     = pair_a;
            prev_b     = pair_b;
            if (done) begin
                if (exp_mask_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_mask_q.pop_front();
                    l = exp_lat_q.pop_front();
                    chk("hit_mask", hit_mask, e);
                    if (l >= 0) chk("done_latency", cyc - start_cyc, l);
                end
            end
            if (s_done) begin
                s_done_seen = 1'b1;
                s_mask      = s_hit_mask;
            end
            if (s_pair_valid) s_pv_seen = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wr_obj(input int idx, input int act, input int x, input int y,
                          input int w, input int h);
        @(posedge clk); #1;
        wr_en     = 1'b1;
        wr_idx    = idx[1:0];
        wr_active = act[0];
        wr_x = 8'(x); wr_y = 8'(y); wr_w = 8'(w); wr_h = 8'(h);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic push_pair(input int a, input int b);
        exp_pair_q.push_back({a[1:0], b[1:0]});
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_scan(input logic [3:0] m, input int lat, input int budget);
        exp_mask_q.push_back(m);
        exp_lat_q.push_back(lat);
        pulse_start();
        wait_done(budget);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pair_valid", pair_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_hit_mask", hit_mask, 0);
        chk("idle_pair_valid", pair_valid, 0);
        chk("idle_pair_a", pair_a, 0);
        chk("idle_pair_b", pair_b, 0);

        // 1: all inactive
        run_scan(4'b0000, 6, 50);

        // 2: simple overlap
        wr_obj(0, 1, 10, 10, 5, 5);
        wr_obj(1, 1, 12, 12, 5, 5);
        wr_obj(2, 0, 0, 0, 0, 0);
        wr_obj(3, 0, 0, 0, 0, 0);
        push_pair(0, 1);
        run_scan(4'b0011, 7, 50);

        // 3: shared edge, inclusive vs strict instance
        wr_obj(0, 1, 0, 0, 4, 4);
        wr_obj(1, 1, 4, 0, 4, 4);
        s_done_seen = 1'b0;
        s_pv_seen   = 1'b0;
        push_pair(0, 1);
        run_scan(4'b0011, 7, 50);
        chk("strict_done_seen", s_done_seen, 1);
        chk("strict_hit_mask", s_mask, 0);
        chk("strict_pair_valid_seen", s_pv_seen, 0);

        // 4: extents past 255 must not wrap
        wr_obj(0, 1, 250, 0, 10, 10);
        wr_obj(1, 1, 5, 0, 3, 3);
        wr_obj(2, 1, 255, 5, 0, 0);
        wr_obj(3, 0, 0, 0, 0, 0);
        push_pair(0, 2);
        run_scan(4'b0101, 7, 50);

        // 5: all overlap, consumer stalls
        for (int k = 0; k < 4; k++) wr_obj(k, 1, 0, 0, 8, 8);
        push_pair(0, 1); push_pair(0, 2); push_pair(0, 3);
        push_pair(1, 2); push_pair(1, 3); push_pair(2, 3);
        stall_n = 5;
        run_scan(4'b1111, -1, 300);
        stall_n = 0;
        chk("stall_pairs_left", exp_pair_q.size(), 0);

        // 6a: write and start while busy are ignored
        wr_obj(0, 1, 10, 10, 5, 5);
        wr_obj(1, 1, 12, 12, 5, 5);
        wr_obj(2, 0, 0, 0, 0, 0);
        wr_obj(3, 0, 0, 0, 0, 0);
        push_pair(0, 1);
        exp_mask_q.push_back(4'b0011);
        exp_lat_q.push_back(7);
        pulse_start();
        start = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_active = 1'b0;
        wr_x = 8'd200; wr_y = 8'd200; wr_w = 8'd1; wr_h = 8'd1;
        repeat (2) @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        wait_done(50);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("second_start_ignored", busy, 0);
        push_pair(0, 1);
        run_scan(4'b0011, 7, 50);

        // 6b: reset during EMIT
        stall_n = 100;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (pair_valid) seen = 1'b1;
        end
        chk("emit_reached", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pair_valid", pair_valid, 0);
        chk("midrst_hit_mask", hit_mask, 0);
        chk("midrst_pair_ab", {pair_a, pair_b}, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        stall_n = 0;
        repeat (3) @(posedge clk);
        run_scan(4'b0000, 6, 50);
        chk("mask_queue_empty", exp_mask_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
